alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- 32-bit integer ALU stage for the pipelined MIPS-style CPU, sitting in the execute stage.
- Computes one of 16 operations selected by a 4-bit opcode on operands A and B.
- Result C and signed-overflow flag Over are registered: one clock of latency.
- Downstream logic (exception or trap handling) consumes Over.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is supported; shift amounts use the low 5 bits.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  clock enable. 1 = capture new result; 0 = hold outputs (pipeline stall).
- A  input  32  operand A. Also the shift amount source, A[4:0].
- B  input  32  operand B. Also the shifted data.
- Op  input  4  operation select.
- C  output  32  registered result.
- Over  output  1  registered signed-overflow flag.

Behaviour:
- Reset: while reset=1, C=0 and Over=0 immediately, independent of clk. Reset has priority over en.
- Clock: on the rising edge with reset=0 and en=1, C <= f(Op,A,B) and Over <= ovf(Op,A,B). With en=0, C and Over hold.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Reset mid-operation: the in-flight result is discarded. The first valid result appears one edge after reset deasserts.
- Opcode map (all arithmetic wraps mod 2^32; Over=0 unless stated):
  - 0000 ADD: A+B. Over=1 on signed overflow, i.e. A and B share a sign and the sum's sign differs.
  - 0001 SUB: A-B. Over=1 on signed overflow, i.e. A and B differ in sign and the result's sign differs from A.
  - 0010 AND: A&B.
  - 0011 OR: A|B.
  - 0100 XOR: A^B.
  - 0101 NOR: ~(A|B).
  - 0110 SLTU: 1 if A<B unsigned, else 0.
  - 0111 SLT: 1 if A<B signed (two's complement), else 0.
  - 1000 SLL: B << A[4:0], zero fill.
  - 1001 SRL: B >> A[4:0], zero fill.
  - 1010 SRA: B >>> A[4:0], sign fill from B[31].
  - 1011 LUI: {B[15:0], 16'h0000}.
  - 1100 ADDU: A+B, Over=0.
  - 1101 SUBU: A-B, Over=0.
  - 1110 PASSB: B.
  - 1111 reserved: C=0, Over=0.
- Boundaries:
  - Shift amount 0 returns B unchanged.
  - Bits A[31:5] are ignored for shifts.
  - SLT/SLTU with A==B gives 0.
  - C is still written on overflow; the consumer decides whether to squash it.
- Combinational datapath feeds a single register bank. No internal state beyond C and Over.

Test Plan:
- Reset asserted asynchronously between edges -> C=0, Over=0 immediately. After release, with A=11, B=0xFFFFFD66 (-666), Op=0111 (SLT): one edge later C=0x00000000, Over=0.
- A=11, B=0xFFFFFD66, Op=0110 (SLTU) -> C=0x00000001. With Op=0001 (SUB) -> C=0x000002A5 (677), Over=0.
- A=0x7FFFFFFF, B=1: Op=0000 -> C=0x80000000, Over=1. Same operands with Op=1100 -> C=0x80000000, Over=0.
- A=0x80000000, B=1, Op=0001 -> C=0x7FFFFFFF, Over=1.
- B=0x80000000, A=4: Op=1010 -> C=0xF8000000; Op=1001 -> 0x08000000. B=0x00000001, A=0x0000003F, Op=1000 -> 0x80000000.
- en=0 for 3 cycles while Op and A change -> C and Over unchanged. en=1 with B=0x00001234, Op=1011 -> C=0x12340000 after the next edge.

Source files
------------

// File: rtl/alu_unit_if.sv
// Execute-stage ALU bus: enable, operands and opcode in; registered result and
// signed-overflow flag out.
interface alu_unit_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       Op;
    logic [WIDTH-1:0] C;
    logic             Over;

    modport master (
        output en, A, B, Op,
        input  C, Over
    );

    modport slave (
        input  en, A, B, Op,
        output C, Over
    );
endinterface

// File: rtl/alu_unit.sv
// 32-bit MIPS-style execute-stage ALU: 16 operations, one register stage for the
// result and the signed-overflow flag, clock enable for pipeline stalls.
module alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    alu_unit_if.slave bus
);

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_NOR   = 4'b0101,
        OP_SLTU  = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_SLL   = 4'b1000,
        OP_SRL   = 4'b1001,
        OP_SRA   = 4'b1010,
        OP_LUI   = 4'b1011,
        OP_ADDU  = 4'b1100,
        OP_SUBU  = 4'b1101,
        OP_PASSB = 4'b1110,
        OP_RSVD  = 4'b1111
    } op_e;

    op_e op;
    assign op = op_e'(bus.Op);

    // One shared adder serves add, subtract and both set-less-than compares.
    logic             use_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             add_ovf;
    logic             lt_unsigned;
    logic             lt_signed;

    always_comb begin
        use_sub = 1'b0;
        if (op inside {OP_SUB, OP_SUBU, OP_SLT, OP_SLTU})
            use_sub = 1'b1;
    end

    assign b_eff     = use_sub ? ~bus.B : bus.B;
    assign sum_ext   = {1'b0, bus.A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, use_sub};
    assign sum       = sum_ext[WIDTH-1:0];
    assign carry_out = sum_ext[WIDTH];

    assign add_ovf     = (bus.A[WIDTH-1] == b_eff[WIDTH-1]) &&
                         (sum[WIDTH-1] != bus.A[WIDTH-1]);
    assign lt_unsigned = ~carry_out;
    assign lt_signed   = sum[WIDTH-1] ^ add_ovf;

    // Right barrel shifter; left shifts reuse it by bit-reversing in and out.
    logic [4:0]       shamt;
    logic             shift_left;
    logic             fill;
    logic [WIDTH-1:0] sh_s0;
    logic [WIDTH-1:0] sh_s1;
    logic [WIDTH-1:0] sh_s2;
    logic [WIDTH-1:0] sh_s3;
    logic [WIDTH-1:0] sh_s4;
    logic [WIDTH-1:0] sh_s5;
    logic [WIDTH-1:0] sh_out;

    assign shamt      = bus.A[4:0];
    assign shift_left = (op == OP_SLL);
    assign fill       = (op == OP_SRA) && bus.B[WIDTH-1];

    assign sh_s0  = shift_left ? {<<{bus.B}} : bus.B;
    assign sh_s1  = shamt[0] ? {fill, sh_s0[WIDTH-1:1]}          : sh_s0;
    assign sh_s2  = shamt[1] ? {{2{fill}}, sh_s1[WIDTH-1:2]}     : sh_s1;
    assign sh_s3  = shamt[2] ? {{4{fill}}, sh_s2[WIDTH-1:4]}     : sh_s2;
    assign sh_s4  = shamt[3] ? {{8{fill}}, sh_s3[WIDTH-1:8]}     : sh_s3;
    assign sh_s5  = shamt[4] ? {{16{fill}}, sh_s4[WIDTH-1:16]}   : sh_s4;
    assign sh_out = shift_left ? {<<{sh_s5}} : sh_s5;

    logic [WIDTH-1:0] result;
    logic             ovf;

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum;
                ovf    = add_ovf;
            end
            OP_SUB: begin
                result = sum;
                ovf    = add_ovf;
            end
            OP_AND:   result = bus.A & bus.B;
            OP_OR:    result = bus.A | bus.B;
            OP_XOR:   result = bus.A ^ bus.B;
            OP_NOR:   result = ~(bus.A | bus.B);
            OP_SLTU:  result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            OP_SLT:   result = {{(WIDTH-1){1'b0}}, lt_signed};
            OP_SLL:   result = sh_out;
            OP_SRL:   result = sh_out;
            OP_SRA:   result = sh_out;
            OP_LUI:   result = {bus.B[15:0], 16'h0000};
            OP_ADDU:  result = sum;
            OP_SUBU:  result = sum;
            OP_PASSB: result = bus.B;
            OP_RSVD:  result = '0;
            default:  result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.C    <= '0;
            bus.Over <= 1'b0;
        end else if (bus.en) begin
            bus.C    <= result;
            bus.Over <= ovf;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: reset/stall sequences, a directed vector
// table and randomized vectors against an arithmetic reference model.
module tb_alu_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;

    alu_unit_if #(.WIDTH(32)) bus ();

    alu_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: C got %h, expected %h", name, got, exp);
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: Over got %b, expected %b", name, got, exp);
    endtask

    task automatic drive(input logic e, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.en = e;
        bus.Op = op;
        bus.A  = a;
        bus.B  = b;
    endtask

    // Reference: signed arithmetic in 64 bits, overflow = result outside int32 range.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] c, output logic o);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = 32'h0;
        o  = 1'b0;
        case (op)
            4'h0: begin r = sa + sb; c = a + b; o = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'h1: begin r = sa - sb; c = a - b; o = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'h2: c = a & b;
            4'h3: c = a | b;
            4'h4: c = a ^ b;
            4'h5: c = ~(a | b);
            4'h6: c = (a < b) ? 32'd1 : 32'd0;
            4'h7: c = (sa < sb) ? 32'd1 : 32'd0;
            4'h8: c = b << a[4:0];
            4'h9: c = b >> a[4:0];
            4'hA: c = $signed(b) >>> a[4:0];
            4'hB: c = {b[15:0], 16'h0000};
            4'hC: c = a + b;
            4'hD: c = a - b;
            4'hE: c = b;
            default: c = 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom();
    endfunction

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_c;
        logic        exp_o;

        vecs.push_back('{"sltu_neg",   4'h6, 32'd11,        32'hFFFF_FD66, 32'h0000_0001, 1'b0});
        vecs.push_back('{"sub_677",    4'h1, 32'd11,        32'hFFFF_FD66, 32'h0000_02A5, 1'b0});
        vecs.push_back('{"add_ovf",    4'h0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b1});
        vecs.push_back('{"addu_noovf", 4'hC, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0});
        vecs.push_back('{"sub_ovf",    4'h1, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1});
        vecs.push_back('{"sub_ovf_neg",4'h1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
        vecs.push_back('{"add_ovf_neg",4'h0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1});
        vecs.push_back('{"subu_wrap",  4'hD, 32'h0000_0000, 32'd1,         32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"sra_4",      4'hA, 32'd4,         32'h8000_0000, 32'hF800_0000, 1'b0});
        vecs.push_back('{"srl_4",      4'h9, 32'd4,         32'h8000_0000, 32'h0800_0000, 1'b0});
        vecs.push_back('{"sll_31",     4'h8, 32'h0000_003F, 32'h0000_0001, 32'h8000_0000, 1'b0});
        vecs.push_back('{"sra_amt0",   4'hA, 32'h0000_0020, 32'h8000_1234, 32'h8000_1234, 1'b0});
        vecs.push_back('{"sll_amt0",   4'h8, 32'hFFFF_FFE0, 32'h8000_1234, 32'h8000_1234, 1'b0});
        vecs.push_back('{"slt_eq",     4'h7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
        vecs.push_back('{"sltu_eq",    4'h6, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0});
        vecs.push_back('{"slt_neg",    4'h7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0});
        vecs.push_back('{"sltu_big",   4'h6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0});
        vecs.push_back('{"and",        4'h2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0});
        vecs.push_back('{"or",         4'h3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0});
        vecs.push_back('{"xor",        4'h4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0});
        vecs.push_back('{"nor_zero",   4'h5, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"lui",        4'hB, 32'h1111_1111, 32'hABCD_1234, 32'h1234_0000, 1'b0});
        vecs.push_back('{"passb",      4'hE, 32'h5555_5555, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{"reserved",   4'hF, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b0});

        // Reset held through an edge with enable high.
        drive(1'b1, 4'h0, 32'h7FFF_FFFF, 32'd1);
        tick();
        check32("reset_c", bus.C, 32'h0);
        check1("reset_over", bus.Over, 1'b0);

        reset = 1'b0;
        tick();
        check32("first_add_c", bus.C, 32'h8000_0000);
        check1("first_add_over", bus.Over, 1'b1);

        // Asynchronous reset between edges clears outputs at once.
        #2;
        reset = 1'b1;
        #1;
        check32("async_reset_c", bus.C, 32'h0);
        check1("async_reset_over", bus.Over, 1'b0);
        tick();
        check32("reset_prio_c", bus.C, 32'h0);
        reset = 1'b0;
        drive(1'b1, 4'h6, 32'd11, 32'hFFFF_FD66);
        tick();
        check32("post_reset_sltu_c", bus.C, 32'h0000_0001);
        drive(1'b1, 4'h7, 32'd11, 32'hFFFF_FD66);
        tick();
        check32("post_reset_slt_c", bus.C, 32'h0);
        check1("post_reset_slt_over", bus.Over, 1'b0);

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            tick();
            check32(vecs[i].name, bus.C, vecs[i].c);
            check1(vecs[i].name, bus.Over, vecs[i].ovf);
        end

        // Stall: outputs hold while inputs change.
        drive(1'b1, 4'h0, 32'h7FFF_FFFF, 32'd1);
        tick();
        check32("pre_stall_c", bus.C, 32'h8000_0000);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'(k + 2), 32'(k * 7 + 3), 32'h0000_1234);
            tick();
            check32("stall_hold_c", bus.C, 32'h8000_0000);
            check1("stall_hold_over", bus.Over, 1'b1);
        end
        drive(1'b1, 4'hB, 32'h0, 32'h0000_1234);
        tick();
        check32("unstall_lui_c", bus.C, 32'h1234_0000);
        check1("unstall_lui_over", bus.Over, 1'b0);

        exp_c = 32'h1234_0000;
        exp_o = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic        e;
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            e  = ($urandom_range(0, 7) != 0);
            op = 4'($urandom_range(0, 15));
            a  = pick_operand();
            b  = pick_operand();
            drive(e, op, a, b);
            if (e) model(op, a, b, exp_c, exp_o);
            tick();
            check32("rand_c", bus.C, exp_c);
            check1("rand_over", bus.Over, exp_o);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
